// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract sequencer.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-right register presenting its LSB serially; load wins over shift.
// Zero latency on ser_out after the loading edge; no backpressure, shifts whenever shift=1.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_dat,
  output logic         ser_out
);

  logic [W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = load_dat;
    end else if (shift) begin
      sh_d = {1'b0, sh_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign ser_out = sh_q[0];

endmodule

// File: rtl/serial_add_sequencer.sv
// Drives an external 1-bit full adder LSB-first to add/subtract WIDTH-bit operands; done WIDTH+1 cycles after start.
// No backpressure: start is only honoured in IDLE/DONE and ignored while busy; results hold until the next accepted start.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             run;
  logic             accept;
  logic             a_ser;
  logic             b_ser;

  assign run    = (state_q == RUN);
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  piso_shreg #(.W(WIDTH)) u_a_sh (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift    (run),
    .load_dat (a),
    .ser_out  (a_ser)
  );

  // Subtract is A + ~B + 1, so B is inverted on the way in.
  piso_shreg #(.W(WIDTH)) u_b_sh (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift    (run),
    .load_dat (sub ? ~b : b),
    .ser_out  (b_ser)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB; publish everything in one edge.
          state_d = DONE;
          sum_d   = sum_sh_d;
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
        end
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign fa_a   = run & a_ser;
  assign fa_b   = run & b_ser;
  assign fa_cin = run & carry_q;
  assign busy   = run;
  assign done   = (state_q == DONE);
  assign sum    = sum_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer with a behavioural full adder on the fa_* port.
module tb_serial_add_sequencer;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       cin_i;
  logic       fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t exp_q[$];

  serial_add_sequencer #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sub     (sub_i),
    .a       (a_i),
    .b       (b_i),
    .cin     (cin_i),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_cin  (fa_cin),
    .fa_s    (fa_s),
    .fa_cout (fa_cout),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf)
  );

  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic res_t model(input logic s, input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
    res_t       r;
    logic [7:0] bb;
    logic [8:0] full;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, (s ? 1'b1 : c)};
    r.s  = full[7:0];
    r.c  = full[8];
    r.v  = (a[7] == bb[7]) && (full[7] != a[7]);
    return r;
  endfunction

  // Result scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sum", {24'd0, sum}, {24'd0, e.s});
        check("cout", {31'd0, cout}, {31'd0, e.c});
        check("ovf", {31'd0, ovf}, {31'd0, e.v});
      end
    end
  end

  // One operation; optionally pulses start with junk operands inj_at cycles into RUN.
  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input res_t exp, input int inj_at);
    logic [7:0] beff;
    logic       rc;
    int         k;
    int         busy_n;
    bit         got;
    beff   = s ? ~b : b;
    rc     = s ? 1'b1 : c;
    k      = 0;
    busy_n = 0;
    got    = 0;
    @(negedge clk);
    sub_i = s; a_i = a; b_i = b; cin_i = c; start = 1'b1;
    exp_q.push_back(exp);
    while (k < 20 && !got) begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (inj_at != 0 && k == inj_at) begin
        start = 1'b1; a_i = 8'hAA; b_i = 8'h55; sub_i = ~s; cin_i = 1'b1;
      end
      if (inj_at != 0 && k == inj_at + 1) start = 1'b0;
      if (busy) busy_n++;
      if (k <= 8) begin
        check("fa_a", {31'd0, fa_a}, {31'd0, a[k-1]});
        check("fa_b", {31'd0, fa_b}, {31'd0, beff[k-1]});
        check("fa_cin", {31'd0, fa_cin}, {31'd0, rc});
        rc = (a[k-1] & beff[k-1]) | (rc & (a[k-1] ^ beff[k-1]));
      end
      if (done) got = 1;
    end
    check("done_latency", k, 9);
    check("busy_cycles", busy_n, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    res_t e;
    int   k;
    int   busy_n;
    int   dn;

    vecs[0] = '{1'b0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub_i = 1'b0; a_i = 8'h5A; b_i = 8'hA5; cin_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_fa_a", {31'd0, fa_a}, 32'd0);
    check("rst_fa_b", {31'd0, fa_b}, 32'd0);
    check("rst_fa_cin", {31'd0, fa_cin}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      e.s = vecs[i].s; e.c = vecs[i].c; e.v = vecs[i].v;
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, e, 0);
    end

    // Idle: adder drive stays low and results hold regardless of input activity.
    @(negedge clk);
    a_i = 8'hFF; b_i = 8'hFF; cin_i = 1'b1; sub_i = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_fa_a", {31'd0, fa_a}, 32'd0);
    check("idle_fa_b", {31'd0, fa_b}, 32'd0);
    check("idle_fa_cin", {31'd0, fa_cin}, 32'd0);
    check("idle_sum_hold", {24'd0, sum}, 32'hFF);
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      logic       s, c;
      logic [7:0] a, b;
      s = 1'($urandom_range(1)); c = 1'($urandom_range(1));
      a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
      run_op(s, a, b, c, model(s, a, b, c), 0);
    end

    // start pulsed mid-RUN is ignored.
    run_op(1'b0, 8'h21, 8'h13, 1'b0, model(1'b0, 8'h21, 8'h13, 1'b0), 3);
    repeat (12) @(negedge clk);
    check("inj_no_extra_op", exp_q.size(), 0);

    // start held through DONE: back-to-back without visiting IDLE.
    @(negedge clk);
    sub_i = 1'b0; a_i = 8'h35; b_i = 8'h4A; cin_i = 1'b0; start = 1'b1;
    exp_q.push_back(model(1'b0, 8'h35, 8'h4A, 1'b0));
    k = 0;
    while (k < 20 && done !== 1'b1) begin
      @(negedge clk);
      k++;
      if (k == 1) begin a_i = 8'h01; b_i = 8'h02; end
    end
    check("b2b_first_latency", k, 9);
    exp_q.push_back(model(1'b0, 8'h01, 8'h02, 1'b0));
    k = 0; busy_n = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        check("b2b_direct_run", {31'd0, busy}, 32'd1);
      end
      if (busy) busy_n++;
    end while (k < 20 && done !== 1'b1);
    check("b2b_second_latency", k, 9);
    check("b2b_busy_cycles", busy_n, 8);
    check("b2b_sum", {24'd0, sum}, 32'h03);

    // Async reset at bit 4 of an add abandons it.
    @(negedge clk);
    sub_i = 1'b0; a_i = 8'h12; b_i = 8'h34; cin_i = 1'b1; start = 1'b1;
    exp_q.push_back(model(1'b0, 8'h12, 8'h34, 1'b1));
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
    end
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_sum", {24'd0, sum}, 32'd0);
    check("arst_cout", {31'd0, cout}, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    check("arst_fa_cin", {31'd0, fa_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("no_activity_after_rst", dn, 0);

    run_op(1'b0, 8'h12, 8'h34, 1'b1, model(1'b0, 8'h12, 8'h34, 1'b1), 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
